// File: rtl/montgomery_pkg.sv
// Shared constants and state encoding for the Montgomery datapath sequencers.
package montgomery_pkg;

    localparam int unsigned W               = 1027;
    localparam int unsigned TIMEOUT_DEFAULT = 4096;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE1,
        WAIT1,
        ISSUE2,
        WAIT2,
        FINISH
    } state_t;

endpackage

// File: rtl/adder_watchdog.sv
// Cycle counter that bounds how long the sequencer waits for the shared adder.
module adder_watchdog #(
    parameter int unsigned TIMEOUT = 4096
) (
    input  logic clk_i,
    input  logic reset_i,
    input  logic clear_i,
    input  logic en_i,
    output logic expired_c_o
);

    localparam int unsigned CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    assign expired_c_o = en_i && (cnt_q == CW'(TIMEOUT - 1));

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (en_i && !expired_c_o) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/mod_addsub_ctrl.sv
// Modular add/subtract sequencer: raw pass plus conditional modulus correction
// on a shared W+1-bit mpadder.
module mod_addsub_ctrl
    import montgomery_pkg::*;
#(
    parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic         subtract,
    input  logic [W-1:0] in_a,
    input  logic [W-1:0] in_b,
    input  logic [W-1:0] in_m,
    output logic [W-1:0] result,
    output logic         done,
    output logic         busy,
    output logic         err,
    output logic         add_start,
    output logic         add_subtract,
    output logic [W-1:0] add_in_a,
    output logic [W-1:0] add_in_b,
    input  logic [W:0]   add_result,
    input  logic         add_done
);

    state_t       state_q;
    logic [W-1:0] m_q;
    logic         sub_q;
    logic [W-1:0] result_q;
    logic         done_q;
    logic         busy_q;
    logic         err_q;
    logic         add_start_q;
    logic         add_subtract_q;
    logic [W-1:0] add_in_a_q;
    logic [W-1:0] add_in_b_q;
    logic         wd_clear;
    logic         wd_en;
    logic         wd_expired_c;

    assign result       = result_q;
    assign done         = done_q;
    assign busy         = busy_q;
    assign err          = err_q;
    assign add_start    = add_start_q;
    assign add_subtract = add_subtract_q;
    assign add_in_a     = add_in_a_q;
    assign add_in_b     = add_in_b_q;

    assign wd_clear = (state_q == ISSUE1) || (state_q == ISSUE2);
    assign wd_en    = (state_q == WAIT1)  || (state_q == WAIT2);

    adder_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clk_i       (clk),
        .reset_i     (reset),
        .clear_i     (wd_clear),
        .en_i        (wd_en),
        .expired_c_o (wd_expired_c)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= IDLE;
            m_q            <= '0;
            sub_q          <= 1'b0;
            result_q       <= '0;
            done_q         <= 1'b0;
            busy_q         <= 1'b0;
            err_q          <= 1'b0;
            add_start_q    <= 1'b0;
            add_subtract_q <= 1'b0;
            add_in_a_q     <= '0;
            add_in_b_q     <= '0;
        end else begin
            add_start_q <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        m_q            <= in_m;
                        sub_q          <= subtract;
                        add_in_a_q     <= in_a;
                        add_in_b_q     <= in_b;
                        add_subtract_q <= subtract;
                        add_start_q    <= 1'b1;
                        busy_q         <= 1'b1;
                        state_q        <= ISSUE1;
                    end
                end
                ISSUE1: state_q <= WAIT1;
                WAIT1: begin
                    if (add_done) begin
                        // s is kept in add_in_a for the correction pass
                        if (!sub_q || add_result[W]) begin
                            add_in_a_q     <= add_result[W-1:0];
                            add_in_b_q     <= m_q;
                            add_subtract_q <= !sub_q;
                            add_start_q    <= 1'b1;
                            state_q        <= ISSUE2;
                        end else begin
                            result_q <= add_result[W-1:0];
                            done_q   <= 1'b1;
                            state_q  <= FINISH;
                        end
                    end else if (wd_expired_c) begin
                        err_q   <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                ISSUE2: state_q <= WAIT2;
                WAIT2: begin
                    if (add_done) begin
                        // add path: negative s-m means s was already reduced
                        if (!sub_q && add_result[W]) begin
                            result_q <= add_in_a_q;
                        end else begin
                            result_q <= add_result[W-1:0];
                        end
                        done_q  <= 1'b1;
                        state_q <= FINISH;
                    end else if (wd_expired_c) begin
                        err_q   <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                FINISH: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mod_addsub_ctrl.sv
// Randomized self-checking bench for mod_addsub_ctrl with a latency-3 adder model.
module tb_mod_addsub_ctrl;
    import montgomery_pkg::*;

    localparam int unsigned XW  = W + 1;
    localparam int          LAT = 3;

    logic         clk;
    logic         reset;
    logic         start;
    logic         subtract;
    logic [W-1:0] in_a;
    logic [W-1:0] in_b;
    logic [W-1:0] in_m;
    logic [W-1:0] result;
    logic         done;
    logic         busy;
    logic         err;
    logic         add_start;
    logic         add_subtract;
    logic [W-1:0] add_in_a;
    logic [W-1:0] add_in_b;
    logic [W:0]   add_result;
    logic         add_done;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int starts_seen = 0;
    int dones_seen  = 0;
    int errs_seen   = 0;

    // adder model state
    int         pend_cnt = 0;
    logic [W:0] pend_res;
    bit         mute = 0;

    mod_addsub_ctrl #(
        .TIMEOUT (16)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .subtract     (subtract),
        .in_a         (in_a),
        .in_b         (in_b),
        .in_m         (in_m),
        .result       (result),
        .done         (done),
        .busy         (busy),
        .err          (err),
        .add_start    (add_start),
        .add_subtract (add_subtract),
        .add_in_a     (add_in_a),
        .add_in_b     (add_in_b),
        .add_result   (add_result),
        .add_done     (add_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [W:0] got, input logic [W:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (low 96 bits)", tag, got[95:0], exp[95:0]);
        end
    endtask

    // One clock: settle after the edge, advance the adder model, tally pulses.
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        add_done = 1'b0;
        if (pend_cnt > 0) begin
            pend_cnt--;
            if (pend_cnt == 0) begin
                add_done   = 1'b1;
                add_result = pend_res;
            end
        end
        if (add_start && !mute) begin
            pend_cnt = LAT;
            pend_res = add_subtract ? ({1'b0, add_in_a} - {1'b0, add_in_b})
                                    : ({1'b0, add_in_a} + {1'b0, add_in_b});
        end
        if (add_start) starts_seen++;
        if (done)      dones_seen++;
        if (err)       errs_seen++;
    endtask

    function automatic logic [W-1:0] ref_mod(input logic [W-1:0] a, input logic [W-1:0] b,
                                             input logic [W-1:0] m, input logic sub);
        logic [W:0] x;
        if (!sub) begin
            x = {1'b0, a} + {1'b0, b};
            if (x >= {1'b0, m}) x = x - {1'b0, m};
        end else if (a >= b) begin
            x = {1'b0, a} - {1'b0, b};
        end else begin
            x = {1'b0, a} + {1'b0, m} - {1'b0, b};
        end
        return x[W-1:0];
    endfunction

    function automatic logic [W-1:0] rand_wide();
        logic [W-1:0] v = '0;
        for (int i = 0; i < (W + 31) / 32; i++) v = {v[W-33:0], 32'($urandom)};
        return v;
    endfunction

    // Issue one operation and check result, latency, adder passes and handshake.
    task automatic run_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [W-1:0] m, input logic sub, input bit poke);
        int s0, st0, d0, lat, busy_bad;
        bit got;
        logic [W-1:0] exp_r;
        exp_r = ref_mod(a, b, m, sub);
        in_a = a; in_b = b; in_m = m; subtract = sub; start = 1'b1;
        s0 = cyc; st0 = starts_seen; d0 = dones_seen;
        tick();
        start = 1'b0;
        busy_bad = 0; got = 0; lat = -1;
        for (int i = 0; i < 100 && !got; i++) begin
            if (!busy) busy_bad++;
            if (done) begin
                got = 1;
                lat = cyc - s0 + 1;
            end else begin
                start = poke && (i == 2);
                if (poke && i == 2) begin
                    in_a = ~a; subtract = ~sub;
                end
                tick();
                start = 1'b0;
            end
        end
        check({tag, "_done_seen"}, XW'(got), XW'(1));
        check({tag, "_result"}, XW'(result), XW'(exp_r));
        check({tag, "_latency"}, XW'(lat), XW'((sub && a >= b) ? 6 : 10));
        check({tag, "_passes"}, XW'(starts_seen - st0), XW'((sub && a >= b) ? 1 : 2));
        check({tag, "_busy"}, XW'(busy_bad), XW'(0));
        tick();
        check({tag, "_done_once"}, XW'(dones_seen - d0), XW'(1));
        check({tag, "_busy_drop"}, XW'(busy), XW'(0));
    endtask

    initial begin
        logic [W-1:0] m, a, b, prev;
        int a0, st0, d0, e0, err_cyc;
        reset = 1'b1; start = 1'b0; subtract = 1'b0;
        in_a = '0; in_b = '0; in_m = '0;
        add_result = '0; add_done = 1'b0;
        tick(); tick();
        reset = 1'b0;
        check("rst_result", XW'(result), XW'(0));
        check("rst_done", XW'(done), XW'(0));
        check("rst_busy", XW'(busy), XW'(0));
        check("rst_err", XW'(err), XW'(0));
        check("rst_add_start", XW'(add_start), XW'(0));
        check("rst_add_in_a", XW'(add_in_a), XW'(0));

        run_op("add_5_4", W'(5), W'(4), W'(7), 1'b0, 0);
        run_op("add_3_2", W'(3), W'(2), W'(7), 1'b0, 0);
        run_op("sub_2_5", W'(2), W'(5), W'(7), 1'b1, 0);
        run_op("sub_5_2", W'(5), W'(2), W'(7), 1'b1, 1);
        run_op("add_6_6", W'(6), W'(6), W'(7), 1'b0, 0);
        run_op("add_3_4", W'(3), W'(4), W'(7), 1'b0, 0);
        run_op("add_0_0", W'(0), W'(0), W'(7), 1'b0, 0);
        run_op("sub_4_4", W'(4), W'(4), W'(7), 1'b1, 0);
        run_op("sub_0_6", W'(0), W'(6), W'(7), 1'b1, 0);

        for (int i = 0; i < 400; i++) begin
            m = rand_wide();
            m[W-1] = 1'b0;
            m[W-2] = 1'b1;
            a = rand_wide() % m;
            b = rand_wide() % m;
            if (i == 0) begin a = m - W'(1); b = m - W'(1); end
            if (i == 200) begin a = '0; b = m - W'(1); end
            run_op((i < 200) ? "rnd_add" : "rnd_sub", a, b, m, (i >= 200), (i % 50) == 7);
        end

        // Reset while the correction pass is in flight; the late add_done must be dropped.
        in_a = W'(5); in_b = W'(4); in_m = W'(7); subtract = 1'b0; start = 1'b1;
        st0 = starts_seen;
        tick();
        start = 1'b0;
        for (int i = 0; i < 40 && (starts_seen - st0) < 2; i++) tick();
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("mid_rst_result", XW'(result), XW'(0));
        check("mid_rst_busy", XW'(busy), XW'(0));
        check("mid_rst_done", XW'(done), XW'(0));
        check("mid_rst_add_start", XW'(add_start), XW'(0));
        check("mid_rst_add_sub", XW'(add_subtract), XW'(0));
        check("mid_rst_add_in_b", XW'(add_in_b), XW'(0));
        d0 = dones_seen;
        for (int i = 0; i < 5; i++) tick();
        check("stale_done_ignored", XW'(dones_seen - d0), XW'(0));
        check("stale_busy", XW'(busy), XW'(0));
        run_op("post_rst_sub", W'(2), W'(5), W'(7), 1'b1, 0);

        // Adder never answers: watchdog must abort with err.
        prev = result;
        mute = 1;
        in_a = W'(1); in_b = W'(2); in_m = W'(7); subtract = 1'b0; start = 1'b1;
        st0 = starts_seen; d0 = dones_seen; e0 = errs_seen;
        tick();
        start = 1'b0;
        a0 = cyc;
        check("to_add_start", XW'(add_start), XW'(1));
        err_cyc = -1;
        for (int i = 0; i < 60 && err_cyc < 0; i++) begin
            if (err) begin
                err_cyc = cyc;
                check("to_busy_at_err", XW'(busy), XW'(0));
            end else begin
                start = (i == 4);
                tick();
                start = 1'b0;
            end
        end
        check("to_err_delay", XW'(err_cyc - a0), XW'(17));
        check("to_no_done", XW'(dones_seen - d0), XW'(0));
        check("to_one_pass", XW'(starts_seen - st0), XW'(1));
        check("to_result_kept", XW'(result), XW'(prev));
        tick();
        check("to_err_once", XW'(errs_seen - e0), XW'(1));
        check("to_idle_busy", XW'(busy), XW'(0));
        mute = 0;
        run_op("post_to_add", W'(5), W'(4), W'(7), 1'b0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
